// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_deserializer
// Description : UART receive front-end; 16x-oversampled start/data/parity/stop
//               sampling with valid/ack handshake and error flags.
//               Optional macro UART_RX_MAJORITY_VOTE_EN: 3-sample bit voting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic                 rx_in,
    input  logic [1:0]           parity_type,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int                 c_IDX_W    = $clog2(DATA_BITS);
    localparam logic [3:0]         c_CNT_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]         c_CNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rx_meta, r_rx_s;
    logic                 r_bd_meta, r_bd_s, r_bd_d;
    logic [3:0]           r_tick_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_armed;
    logic                 r_par_acc, r_par_en, r_par_odd, r_par_bad;
    logic                 w_tick, w_bit, w_par_en;
    logic                 w_cnt_clr, w_start_ok, w_shift_en, w_last_bit, w_par_smp, w_complete;

    assign w_tick   = r_bd_s & ~r_bd_d;
    assign w_par_en = parity_type[0] ^ parity_type[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_bd_meta <= 1'b0;
            r_bd_s    <= 1'b0;
            r_bd_d    <= 1'b0;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
            r_bd_meta <= baud_clk;
            r_bd_s    <= r_bd_meta;
            r_bd_d    <= r_bd_s;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Two most recent tick samples; the decision votes them with the current one.
    logic [1:0] r_hist;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hist <= 2'b11;
        end else if (w_tick) begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_start_ok  = 1'b0;
        w_shift_en  = 1'b0;
        w_last_bit  = 1'b0;
        w_par_smp   = 1'b0;
        w_complete  = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (r_armed && !r_rx_s) begin
                        w_state_nxt = S_START;
                        w_cnt_clr   = 1'b1;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == c_CNT_MID) begin
                        w_cnt_clr = 1'b1;
                        if (!w_bit) begin
                            w_state_nxt = S_DATA;
                            w_start_ok  = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == c_CNT_LAST) begin
                        w_cnt_clr  = 1'b1;
                        w_shift_en = 1'b1;
                        if (r_bit_idx == c_IDX_LAST) begin
                            w_last_bit  = 1'b1;
                            w_state_nxt = w_par_en ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (r_tick_cnt == c_CNT_LAST) begin
                        w_cnt_clr   = 1'b1;
                        w_par_smp   = 1'b1;
                        w_state_nxt = S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == c_CNT_LAST) begin
                        w_cnt_clr   = 1'b1;
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_par_acc   <= 1'b0;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_par_bad   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (w_tick) begin
                if (w_cnt_clr || r_state == S_IDLE) begin
                    r_tick_cnt <= '0;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
            // A break leaves the line low; only a high level re-arms start detection.
            if (w_tick && r_state == S_IDLE && r_rx_s) begin
                r_armed <= 1'b1;
            end
            if (w_start_ok) begin
                r_bit_idx <= '0;
                r_par_acc <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
                r_par_acc <= r_par_acc ^ w_bit;
            end
            if (w_last_bit) begin
                r_par_en  <= w_par_en;
                r_par_odd <= parity_type[0];
                r_par_bad <= 1'b0;
            end
            if (w_par_smp) begin
                r_par_bad <= r_par_odd ? ~(r_par_acc ^ w_bit) : (r_par_acc ^ w_bit);
            end
            if (w_complete) begin
                data_out    <= r_shift;
                data_valid  <= 1'b1;
                parity_err  <= r_par_en & r_par_bad;
                framing_err <= ~w_bit;
                overrun_err <= data_valid & ~data_ack;
                if (!w_bit) begin
                    r_armed <= 1'b0;
                end
            end else if (data_ack && data_valid) begin
                data_valid  <= 1'b0;
                parity_err  <= 1'b0;
                framing_err <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_deserializer
// Description : Scoreboard bench for uart_rx_deserializer with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       o;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       baud_clk = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, parity_err, framing_err, overrun_err;

    exp_t       q[$];
    logic       done = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       pv = 1'b0;
    logic       pa = 1'b0;
    logic       pr = 1'b1;
    logic [7:0] pd = 8'h00;
    logic [2:0] pf = 3'b000;
    exp_t       e;

    uart_rx_deserializer #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .baud_clk    (baud_clk),
        .rx_in       (rx_in),
        .parity_type (parity_type),
        .data_ack    (data_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    always #10 clock = ~clock;
    always #40 baud_clk = ~baud_clk;

    task automatic ticks(input int n);
        repeat (n) @(posedge baud_clk);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        ticks(n);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(par_bit);
        send_bit(stop_bit);
    endtask

    task automatic do_ack();
        @(posedge clock);
        #1 data_ack = 1'b1;
        @(posedge clock);
        #1 data_ack = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Stimulus: expectations are queued before each frame is driven.
    initial begin
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        idle(20);

        q.push_back('{d: 8'hA5, p: 1'b0, f: 1'b0, o: 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        do_ack();
        idle(4);

        parity_type = 2'b10;
        q.push_back('{d: 8'h3C, p: 1'b1, f: 1'b0, o: 1'b0});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        do_ack();
        idle(4);

        parity_type = 2'b01;
        q.push_back('{d: 8'h3C, p: 1'b0, f: 1'b0, o: 1'b0});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        do_ack();
        parity_type = 2'b00;
        idle(4);

        rx_in = 1'b0;
        ticks(4);
        idle(40);
        q.push_back('{d: 8'h55, p: 1'b0, f: 1'b0, o: 1'b0});
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        do_ack();
        idle(4);

        q.push_back('{d: 8'h81, p: 1'b0, f: 1'b1, o: 1'b0});
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b0;
        do_ack();
        ticks(40);
        idle(20);
        q.push_back('{d: 8'h12, p: 1'b0, f: 1'b0, o: 1'b0});
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        do_ack();
        idle(4);

        q.push_back('{d: 8'h01, p: 1'b0, f: 1'b0, o: 1'b0});
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        q.push_back('{d: 8'h02, p: 1'b0, f: 1'b0, o: 1'b1});
        send_frame(8'h02, 1'b0, 1'b0, 1'b1);
        do_ack();
        idle(4);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx_in = 1'b1;
        ticks(8);
        pulse_reset();
        idle(20);
        q.push_back('{d: 8'h0F, p: 1'b0, f: 1'b0, o: 1'b0});
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        do_ack();
        idle(4);
        done = 1'b1;
    end

    // Monitor: compares every new presentation against the queue head.
    initial begin
        forever begin
            @(negedge clock);
            if (pr && !reset) begin
                n_cmp++;
                if ({data_out, data_valid, parity_err, framing_err, overrun_err} != 12'h000) begin
                    n_bad++;
                    $display("FAIL reset_state: got d=%h v=%b p=%b f=%b o=%b want all 0",
                             data_out, data_valid, parity_err, framing_err, overrun_err);
                end
            end else if (!reset) begin
                if (data_valid && (!pv || data_out != pd ||
                                   {parity_err, framing_err, overrun_err} != pf)) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_bad++;
                        $display("FAIL spurious_frame: got d=%h p=%b f=%b o=%b want no frame",
                                 data_out, parity_err, framing_err, overrun_err);
                    end else begin
                        e = q.pop_front();
                        if ({data_out, parity_err, framing_err, overrun_err} != e) begin
                            n_bad++;
                            $display("FAIL frame: got d=%h p=%b f=%b o=%b want d=%h p=%b f=%b o=%b",
                                     data_out, parity_err, framing_err, overrun_err,
                                     e.d, e.p, e.f, e.o);
                        end
                    end
                end else if (pv && !data_valid) begin
                    n_cmp++;
                    if (!pa || {parity_err, framing_err, overrun_err} != 3'b000) begin
                        n_bad++;
                        $display("FAIL ack_clear: got ack=%b p=%b f=%b o=%b want ack=1 flags 000",
                                 pa, parity_err, framing_err, overrun_err);
                    end
                end
            end
            pv = data_valid;
            pa = data_ack;
            pr = reset;
            pd = data_out;
            pf = {parity_err, framing_err, overrun_err};
            if (done) begin
                n_cmp++;
                if (q.size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_frames: got %0d outstanding want 0", q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
